// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   OP_*      : mul/div operation encodings as presented on op_i
//   state_t   : sequencer FSM encoding
//   helpers   : operation decode and a small integer max used for sizing
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Divide ops have bit 1 set; signed ops (MULT, DIV) have bit 0 clear.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk, rst (async, active-low), flush (abandons the division)
//   start             : load dividend/divisor, iterations begin next cycle
//   dividend, divisor : unsigned operands, divisor must be non-zero
//   quotient, remainder, done : result of the final iteration, valid while done=1
// done is raised during the last iteration and quotient/remainder present that
// iteration's combinational result, so the caller can register it on the same
// edge that retires the division.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;   // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] dsr_reg;

    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    always_comb begin
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, dsr_reg});
        // When the trial subtraction fits the true difference is below the
        // divisor, so the low WIDTH bits carry the whole result.
        rem_next  = fits ? (rem_shift[WIDTH-1:0] - dsr_reg) : rem_shift[WIDTH-1:0];
        quo_next  = {quo_reg[WIDTH-2:0], fits};
        last_step = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            rem_reg  <= '0;
            quo_reg  <= '0;
            dsr_reg  <= '0;
        end else if (flush) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dsr_reg  <= divisor;
        end else if (busy_reg) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (last_step) begin
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign done      = busy_reg & last_step;
    assign quotient  = quo_next;
    assign remainder = rem_next;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide controller sitting beside EXE.
//   clk, rst (async, active-low)
//   start_i, op_i, a_i, b_i : op issue from EXE (MULT/MULTU/DIV/DIVU)
//   flush_i                 : cancel in-flight op, blocks acceptance
//   hilo_read_i/write_i     : ID holds MFHI/MFLO or MTHI/MTLO
//   busy_o, stall_o         : unit occupied / freeze IF-ID
//   done_o, hilo_wena_o     : one-cycle result strobe (identical)
//   hi_o, lo_o              : product high/low or remainder/quotient, held
//   div_by_zero_o           : with done_o, the divisor was zero
// Multiplies compute the full product at accept and spend MUL_CYCLES in MUL
// to model the multiplier latency; divides run seq_divider on magnitudes and
// apply the sign fixup on the edge into DONE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hilo_read_i,
    input  logic             hilo_write_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             hilo_wena_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               dbz_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               accept;
    logic               b_zero;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_next;
    logic               div_start;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               div_done;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               mul_last;

    // Operand conditioning. Sign bits only count for the signed ops, so the
    // same sign-extend-and-multiply serves MULT and MULTU, and the same
    // magnitude path serves DIV and DIVU (0x80000000 maps onto itself).
    always_comb begin
        accept    = (state_reg == S_IDLE) & start_i & ~flush_i;
        b_zero    = (b_i == '0);
        a_neg     = op_is_signed(op_i) & a_i[WIDTH-1];
        b_neg     = op_is_signed(op_i) & b_i[WIDTH-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
        a_ext     = {{WIDTH{a_neg}}, a_i};
        b_ext     = {{WIDTH{b_neg}}, b_i};
        prod_next = a_ext * b_ext;
        div_start = accept & op_is_div(op_i) & ~b_zero;
        q_fix     = neg_q_reg ? -div_q : div_q;
        r_fix     = neg_r_reg ? -div_r : div_r;
        mul_last  = (cnt_reg == CNT_W'(MUL_CYCLES - 1));
    end

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_i),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (div_q),
        .remainder(div_r),
        .done     (div_done)
    );

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = S_IDLE;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        if (!op_is_div(op_i)) state_next = S_MUL;
                        else if (b_zero)      state_next = S_DONE;
                        else                  state_next = S_DIV;
                    end
                end
                S_MUL:  if (mul_last) state_next = S_DONE;
                S_DIV:  if (div_done) state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            // Counter restarts on every state change so each state sees 0..N-1.
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (state_reg == S_MUL || state_reg == S_DIV)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_reg  <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            dbz_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            if (accept) begin
                prod_reg  <= prod_next;
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
            end
            // HI/LO only change on an edge entering DONE; otherwise they hold.
            if (accept && op_is_div(op_i) && b_zero) begin
                hi_reg  <= a_i;
                lo_reg  <= '1;
                dbz_reg <= 1'b1;
            end else if (state_reg == S_MUL && state_next == S_DONE) begin
                hi_reg  <= prod_reg[2*WIDTH-1:WIDTH];
                lo_reg  <= prod_reg[WIDTH-1:0];
                dbz_reg <= 1'b0;
            end else if (state_reg == S_DIV && state_next == S_DONE) begin
                hi_reg  <= r_fix;
                lo_reg  <= q_fix;
                dbz_reg <= 1'b0;
            end
        end
    end

    // A flush arriving in DONE must kill the write strobe in that same cycle.
    assign busy_o        = (state_reg != S_IDLE);
    assign stall_o       = busy_o & (start_i | hilo_read_i | hilo_write_i);
    assign done_o        = (state_reg == S_DONE) & ~flush_i;
    assign hilo_wena_o   = done_o;
    assign div_by_zero_o = done_o & dbz_reg;
    assign hi_o          = hi_reg;
    assign lo_o          = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a cycle-level arithmetic model of
// the op stream, a per-cycle compare process, and directed vectors with
// hand-computed results.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 4 + 1;
    localparam int DIV_LAT = 32 + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        rd;
    logic        wr;
    logic        busy_o, stall_o, done_o, hilo_wena_o, div_by_zero_o;
    logic [31:0] hi_o, lo_o;

    muldiv_sequencer #(
        .WIDTH(32), .MUL_CYCLES(4), .DIV_CYCLES(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .op_i         (op),
        .a_i          (a),
        .b_i          (b),
        .flush_i      (flush),
        .hilo_read_i  (rd),
        .hilo_write_i (wr),
        .busy_o       (busy_o),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .hilo_wena_o  (hilo_wena_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_by_zero_o(div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int          cyc = 0;
    bit          pend = 0;
    int          done_cyc = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    bit          m_dbz = 0;
    logic [31:0] held_hi = 0, held_lo = 0;
    bit          held_known = 1;

    function automatic void model_result(input logic [1:0] o, input logic [31:0] x, y,
                                         output logic [31:0] h, l, output bit z,
                                         output int lat);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up, uq, ur;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        z  = 0;
        h  = 0;
        l  = 0;
        lat = MUL_LAT;
        case (o)
            OP_MULT:  begin sp = sx * sy; h = sp[63:32]; l = sp[31:0]; end
            OP_MULTU: begin up = ux * uy; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    h = x; l = 32'hFFFF_FFFF; z = 1; lat = 1;
                end else if (o == OP_DIV) begin
                    sq = sx / sy; sr = sx % sy;
                    l = sq[31:0]; h = sr[31:0]; lat = DIV_LAT;
                end else begin
                    uq = ux / uy; ur = ux % uy;
                    l = uq[31:0]; h = ur[31:0]; lat = DIV_LAT;
                end
            end
        endcase
    endfunction

    initial begin
        int lat;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pend = 0; held_hi = 0; held_lo = 0; held_known = 1;
            end else begin
                if (flush) begin
                    if (pend && cyc == done_cyc) held_known = 0;
                    pend = 0;
                end else if (pend) begin
                    if (cyc == done_cyc) begin
                        pend = 0; held_hi = m_hi; held_lo = m_lo; held_known = 1;
                    end
                end else if (start) begin
                    model_result(op, a, b, m_hi, m_lo, m_dbz, lat);
                    pend = 1;
                    done_cyc = cyc + lat;
                end
                cyc++;
            end
        end
    end

    // ---------------- compare ----------------
    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } req_t;
    req_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        q.push_back('{name, act, exp});
    endtask

    initial begin
        req_t r;
        bit at_done, e_done;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                r = q.pop_front();
                checks++;
                if (r.act !== r.exp) begin
                    errors++;
                    $display("FAIL %s: actual %h, required %h", r.name, r.act, r.exp);
                end
            end
            at_done = pend && (cyc == done_cyc);
            e_done  = at_done && !flush;
            checks += 7;
            if (busy_o !== pend) begin
                errors++; $display("FAIL busy @%0d: actual %b, required %b", cyc, busy_o, pend);
            end
            if (stall_o !== (pend && (start || rd || wr))) begin
                errors++; $display("FAIL stall @%0d: actual %b, required %b", cyc, stall_o, pend && (start || rd || wr));
            end
            if (done_o !== e_done) begin
                errors++; $display("FAIL done @%0d: actual %b, required %b", cyc, done_o, e_done);
            end
            if (hilo_wena_o !== e_done) begin
                errors++; $display("FAIL wena @%0d: actual %b, required %b", cyc, hilo_wena_o, e_done);
            end
            if (div_by_zero_o !== (e_done && m_dbz)) begin
                errors++; $display("FAIL dbz @%0d: actual %b, required %b", cyc, div_by_zero_o, e_done && m_dbz);
            end
            if (at_done || held_known) begin
                if (hi_o !== (at_done ? m_hi : held_hi)) begin
                    errors++; $display("FAIL hi @%0d: actual %h, required %h", cyc, hi_o, at_done ? m_hi : held_hi);
                end
                if (lo_o !== (at_done ? m_lo : held_lo)) begin
                    errors++; $display("FAIL lo @%0d: actual %h, required %h", cyc, lo_o, at_done ? m_lo : held_lo);
                end
            end else begin
                checks -= 2;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, y, eh, el,
                          input logic ez, input int elat);
        int n;
        bit got;
        @(posedge clk); #1;
        op = o; a = x; b = y; start = 1;
        @(posedge clk); #1;
        start = 0;
        n = 1;
        got = 0;
        while (!got && n <= 100) begin
            @(negedge clk);
            if (done_o) got = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        expect_lit("done_seen", 32'(got), 32'd1);
        expect_lit("latency", 32'(n), 32'(elat));
        expect_lit("hi", hi_o, eh);
        expect_lit("lo", lo_o, el);
        expect_lit("dbz", 32'(div_by_zero_o), 32'(ez));
        expect_lit("wena", 32'(hilo_wena_o), 32'd1);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d latency=%0d", o, x, y, hi_o, lo_o, div_by_zero_o, n);
        @(posedge clk); #1;
        expect_lit("wena_pulse_end", 32'(hilo_wena_o), 32'd0);
    endtask

    initial begin
        int dn;
        rst = 0; start = 0; op = 0; a = 0; b = 0; flush = 0; rd = 0; wr = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_lit("reset_busy", 32'(busy_o), 32'd0);
        expect_lit("reset_done", 32'(done_o), 32'd0);
        expect_lit("reset_hi", hi_o, 32'd0);
        expect_lit("reset_lo", lo_o, 32'd0);
        rst = 1;

        run_op(OP_MULT,  32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 5);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 0, 5);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 5);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 0, 33);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 0, 33);
        run_op(OP_DIVU,  32'd7,         32'd0,          32'h0000_0007, 32'hFFFF_FFFF, 1, 1);
        run_op(OP_DIVU,  32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E, 0, 33);
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 32'hFFFF_FFFF, 0, 33);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 1);

        // Busy divide with a HI/LO reader from cycle 3 and a start while busy.
        @(posedge clk); #1;
        op = OP_DIV; a = 32'd100; b = 32'd7; start = 1;
        dn = 0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk); #1;
            start = (k == 5);
            if (k == 5) begin op = OP_MULTU; a = 32'd3; b = 32'd3; end
            rd = (k >= 3 && k <= 34);
            @(negedge clk);
            if (k >= 3 && k <= 33) expect_lit("stall_busy", 32'(stall_o), 32'd1);
            if (k == 34) expect_lit("stall_idle", 32'(stall_o), 32'd0);
            if (k == 33) expect_lit("stall_div_done", 32'(done_o), 32'd1);
            if (k == 33) expect_lit("stall_div_lo", lo_o, 32'h0000_000E);
            if (done_o) dn++;
        end
        rd = 0;
        expect_lit("busy_start_ignored", 32'(dn), 32'd1);

        // Flush in cycle 10 of a divide.
        @(posedge clk); #1;
        op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1;
        dn = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 0;
            flush = (k == 10);
            @(negedge clk);
            if (k == 11) expect_lit("flush_to_idle", 32'(busy_o), 32'd0);
            if (done_o) dn++;
        end
        flush = 0;
        expect_lit("flush_no_done", 32'(dn), 32'd0);

        // Flush beats start in IDLE.
        @(posedge clk); #1;
        op = OP_MULT; a = 32'd5; b = 32'd5; start = 1; flush = 1;
        @(posedge clk); #1;
        start = 0; flush = 0;
        @(negedge clk);
        expect_lit("flush_blocks_accept", 32'(busy_o), 32'd0);

        // Flush in DONE suppresses the write strobe.
        @(posedge clk); #1;
        op = OP_MULT; a = 32'd6; b = 32'd7; start = 1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            start = 0;
            flush = (k == 5);
            @(negedge clk);
            if (k == 5) expect_lit("flush_done_pulse", 32'(done_o), 32'd0);
            if (k == 5) expect_lit("flush_done_wena", 32'(hilo_wena_o), 32'd0);
            if (k == 6) expect_lit("flush_done_idle", 32'(busy_o), 32'd0);
        end
        flush = 0;
        run_op(OP_MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 0, 5);

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        op = OP_MULT; a = 32'd3; b = 32'd4; start = 1;
        @(posedge clk); #1;
        start = 0; rd = 1;
        @(posedge clk); #1;
        expect_lit("mul_busy_pre_rst", 32'(busy_o), 32'd1);
        expect_lit("mul_stall_pre_rst", 32'(stall_o), 32'd1);
        #2;
        rst = 0;
        #1;
        expect_lit("rst_busy", 32'(busy_o), 32'd0);
        expect_lit("rst_stall", 32'(stall_o), 32'd0);
        expect_lit("rst_done", 32'(done_o), 32'd0);
        expect_lit("rst_hi", hi_o, 32'd0);
        expect_lit("rst_lo", lo_o, 32'd0);
        @(posedge clk); #1;
        rd = 0; rst = 1;
        run_op(OP_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 0, 5);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
